// File: rtl/led_pattern_pkg.sv
// led_pattern_pkg
//   Shared types and constants for the LED pattern controller: the per-LED
//   mode encoding, the blink-code sub-state encoding, the blink-code gap
//   multiplier, the PWM counter width and a helper that maps raw 3-bit mode
//   codes (including reserved codes) onto a legal mode.
//   Optional feature macro used by the design: LED_PWM_DIM_EN.
package led_pattern_pkg;

  typedef enum logic [2:0] {
    LED_OFF     = 3'd0,
    LED_ON      = 3'd1,
    LED_BLINK   = 3'd2,
    LED_CODE    = 3'd3,
    LED_ONESHOT = 3'd4
  } led_mode_e;

  typedef enum logic [1:0] {
    PULSE_ON  = 2'd0,
    PULSE_OFF = 2'd1,
    GAP       = 2'd2
  } code_state_e;

  // The dark gap after a blink-code burst lasts this many half-periods
  localparam int CODE_GAP_MULT = 4;

  // Width of the shared PWM counter and of the per-channel duty field
  localparam int PWM_W = 4;

  // Reserved codes 5..7 behave exactly like OFF
  function automatic led_mode_e decode_mode(input logic [2:0] raw);
    case (raw)
      3'd1:    return LED_ON;
      3'd2:    return LED_BLINK;
      3'd3:    return LED_CODE;
      3'd4:    return LED_ONESHOT;
      default: return LED_OFF;
    endcase
  endfunction

endpackage

// File: rtl/led_pattern_ch.sv
// led_pattern_ch
//   One LED channel. Holds the channel mode, half-period, code pulse count,
//   the phase and pulse counters and the blink-code sub-state, and produces
//   the registered pattern level and the one-shot busy flag. Everything
//   advances only on the shared prescaler tick; a config apply overrides
//   any tick activity in the same cycle.
// Ports
//   clk, rst_n     clock, asynchronous active-low reset
//   tick           one-cycle pattern time base strobe
//   apply          load cfg_* into this channel (preempts running pattern)
//   cfg_mode       raw 3-bit mode code
//   cfg_period     half-period in ticks (0 treated as 1)
//   cfg_count      code pulse count (0 treated as 1)
//   led            registered pattern level, 1 = lit
//   busy           high while a one-shot pulse is running
module led_pattern_ch
  import led_pattern_pkg::*;
#(
  parameter int PERIOD_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tick,
  input  logic                apply,
  input  logic [2:0]          cfg_mode,
  input  logic [PERIOD_W-1:0] cfg_period,
  input  logic [3:0]          cfg_count,
  output logic                led,
  output logic                busy
);

  // Two extra bits so the gap length (4x period) never overflows
  localparam int PH_W = PERIOD_W + 2;

  led_mode_e             mode_q,   mode_d;
  code_state_e           state_q,  state_d;
  logic [PERIOD_W-1:0]   period_q, period_d;
  logic [3:0]            count_q,  count_d;
  logic [3:0]            pulse_q,  pulse_d;
  logic [PH_W-1:0]       phase_q,  phase_d;
  logic                  led_q,    led_d;
  logic                  busy_q,   busy_d;

  logic [PH_W-1:0]       phase_inc;
  logic [PH_W-1:0]       half_lim;
  logic [PH_W-1:0]       gap_lim;
  logic                  half_done;
  logic                  gap_done;

  // Phase counter compares: a segment ends on the tick that brings the
  // phase count up to its length
  always_comb begin
    phase_inc = phase_q + 1'b1;
    half_lim  = PH_W'(period_q);
    gap_lim   = half_lim * PH_W'(CODE_GAP_MULT);
    half_done = (phase_inc == half_lim);
    gap_done  = (phase_inc == gap_lim);
  end

  // Channel next-state logic; apply wins over tick
  always_comb begin
    mode_d   = mode_q;
    state_d  = state_q;
    period_d = period_q;
    count_d  = count_q;
    pulse_d  = pulse_q;
    phase_d  = phase_q;
    led_d    = led_q;
    busy_d   = busy_q;

    if (apply) begin
      mode_d   = decode_mode(cfg_mode);
      period_d = (cfg_period == '0) ? PERIOD_W'(1) : cfg_period;
      count_d  = (cfg_count == '0) ? 4'd1 : cfg_count;
      pulse_d  = '0;
      phase_d  = '0;
      state_d  = PULSE_ON;
      led_d    = (mode_d != LED_OFF);
      busy_d   = (mode_d == LED_ONESHOT);
    end else if (tick) begin
      case (mode_q)
        LED_ON: begin
          led_d = 1'b1;
        end
        LED_BLINK: begin
          if (half_done) begin
            phase_d = '0;
            led_d   = ~led_q;
          end else begin
            phase_d = phase_inc;
          end
        end
        LED_CODE: begin
          case (state_q)
            PULSE_ON: begin
              if (half_done) begin
                phase_d = '0;
                state_d = PULSE_OFF;
                led_d   = 1'b0;
              end else begin
                phase_d = phase_inc;
              end
            end
            PULSE_OFF: begin
              if (half_done) begin
                phase_d = '0;
                if (pulse_q + 4'd1 == count_q) begin
                  pulse_d = '0;
                  state_d = GAP;
                  led_d   = 1'b0;
                end else begin
                  pulse_d = pulse_q + 4'd1;
                  state_d = PULSE_ON;
                  led_d   = 1'b1;
                end
              end else begin
                phase_d = phase_inc;
              end
            end
            GAP: begin
              if (gap_done) begin
                phase_d = '0;
                state_d = PULSE_ON;
                led_d   = 1'b1;
              end else begin
                phase_d = phase_inc;
              end
            end
            default: begin
              state_d = PULSE_ON;
            end
          endcase
        end
        LED_ONESHOT: begin
          // Pulse ends by falling back to OFF; led and busy drop together
          if (half_done) begin
            phase_d = '0;
            mode_d  = LED_OFF;
            led_d   = 1'b0;
            busy_d  = 1'b0;
          end else begin
            phase_d = phase_inc;
          end
        end
        default: begin
          mode_d = LED_OFF;
          led_d  = 1'b0;
          busy_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q   <= LED_OFF;
      state_q  <= PULSE_ON;
      period_q <= '0;
      count_q  <= '0;
      pulse_q  <= '0;
      phase_q  <= '0;
      led_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      mode_q   <= mode_d;
      state_q  <= state_d;
      period_q <= period_d;
      count_q  <= count_d;
      pulse_q  <= pulse_d;
      phase_q  <= phase_d;
      led_q    <= led_d;
      busy_q   <= busy_d;
    end
  end

  assign led  = led_q;
  assign busy = busy_q;

endmodule

// File: rtl/led_pattern_ctrl.sv
// led_pattern_ctrl
//   Board status LED pattern controller. Holds the shared prescaler that
//   produces the pattern tick, a one-entry pending config register behind a
//   valid/ready port, and NUM_LED channel instances. A pending write is
//   applied on the next tick; writes to idx >= NUM_LED are accepted and
//   dropped.
//   Optional feature macro: LED_PWM_DIM_EN adds a per-channel 4-bit duty
//   (I_cfg_duty) that gates the pattern with a shared free-running PWM
//   counter.
// Ports
//   I_clk, I_rst_n   clock, asynchronous active-low reset
//   I_cfg_valid      config write request
//   O_cfg_ready      write accepted when valid & ready
//   I_cfg_idx        target LED
//   I_cfg_mode       0 OFF,1 ON,2 BLINK,3 CODE,4 ONESHOT, others OFF
//   I_cfg_period     half-period in ticks
//   I_cfg_count      code pulse count
//   I_cfg_duty       PWM duty (only with LED_PWM_DIM_EN)
//   O_led_out        LED drive, 1 = lit
//   O_busy           per-channel one-shot busy
module led_pattern_ctrl
  import led_pattern_pkg::*;
#(
  parameter int  CLK_FREQ_HZ = 10_000_000,
  parameter int  TICK_HZ     = 1_000,
  parameter int  NUM_LED     = 4,
  parameter int  PERIOD_W    = 16,
  localparam int IDX_W       = (NUM_LED > 1) ? $clog2(NUM_LED) : 1
) (
  input  logic                I_clk,
  input  logic                I_rst_n,
  input  logic                I_cfg_valid,
  output logic                O_cfg_ready,
  input  logic [IDX_W-1:0]    I_cfg_idx,
  input  logic [2:0]          I_cfg_mode,
  input  logic [PERIOD_W-1:0] I_cfg_period,
  input  logic [3:0]          I_cfg_count,
`ifdef LED_PWM_DIM_EN
  input  logic [PWM_W-1:0]    I_cfg_duty,
`endif
  output logic [NUM_LED-1:0]  O_led_out,
  output logic [NUM_LED-1:0]  O_busy
);

  localparam int DIV   = CLK_FREQ_HZ / TICK_HZ;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0]    presc_q,       presc_d;
  logic                pend_valid_q,  pend_valid_d;
  logic [IDX_W-1:0]    pend_idx_q,    pend_idx_d;
  logic [2:0]          pend_mode_q,   pend_mode_d;
  logic [PERIOD_W-1:0] pend_period_q, pend_period_d;
  logic [3:0]          pend_count_q,  pend_count_d;
  logic                tick;
  logic                accept;
  logic                apply_any;
  logic [NUM_LED-1:0]  pattern;

  // Tick is high for the single cycle the prescaler sits at its maximum
  always_comb begin
    tick    = (presc_q == CNT_W'(DIV - 1));
    presc_d = tick ? '0 : presc_q + 1'b1;
  end

  // One-entry pending register: ready is simply "slot empty", so it drops
  // the cycle after capture and comes back the cycle after the apply tick.
  // A write captured in a tick cycle sees an empty slot at that tick and so
  // waits for the next one.
  always_comb begin
    accept        = I_cfg_valid & ~pend_valid_q;
    apply_any     = tick & pend_valid_q;
    pend_valid_d  = pend_valid_q;
    pend_idx_d    = pend_idx_q;
    pend_mode_d   = pend_mode_q;
    pend_period_d = pend_period_q;
    pend_count_d  = pend_count_q;
    if (apply_any) begin
      pend_valid_d = 1'b0;
    end else if (accept) begin
      pend_valid_d  = 1'b1;
      pend_idx_d    = I_cfg_idx;
      pend_mode_d   = I_cfg_mode;
      pend_period_d = I_cfg_period;
      pend_count_d  = I_cfg_count;
    end
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      presc_q       <= '0;
      pend_valid_q  <= 1'b0;
      pend_idx_q    <= '0;
      pend_mode_q   <= '0;
      pend_period_q <= '0;
      pend_count_q  <= '0;
    end else begin
      presc_q       <= presc_d;
      pend_valid_q  <= pend_valid_d;
      pend_idx_q    <= pend_idx_d;
      pend_mode_q   <= pend_mode_d;
      pend_period_q <= pend_period_d;
      pend_count_q  <= pend_count_d;
    end
  end

  assign O_cfg_ready = ~pend_valid_q;

  // Out-of-range indices match no channel, so the write is silently dropped
  for (genvar i = 0; i < NUM_LED; i++) begin : g_ch
    led_pattern_ch #(
      .PERIOD_W (PERIOD_W)
    ) u_ch (
      .clk        (I_clk),
      .rst_n      (I_rst_n),
      .tick       (tick),
      .apply      (apply_any && (pend_idx_q == IDX_W'(i))),
      .cfg_mode   (pend_mode_q),
      .cfg_period (pend_period_q),
      .cfg_count  (pend_count_q),
      .led        (pattern[i]),
      .busy       (O_busy[i])
    );
  end

`ifdef LED_PWM_DIM_EN
  logic [PWM_W-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [PWM_W-1:0] pend_duty_q, pend_duty_d;
  logic [PWM_W-1:0] duty_q [NUM_LED];
  logic [PWM_W-1:0] duty_d [NUM_LED];

  // Duty travels with the pending write and lands in the addressed channel
  always_comb begin
    pwm_cnt_d   = pwm_cnt_q + 1'b1;
    pend_duty_d = accept ? I_cfg_duty : pend_duty_q;
    for (int i = 0; i < NUM_LED; i++) begin
      duty_d[i] = duty_q[i];
      if (apply_any && (pend_idx_q == IDX_W'(i))) begin
        duty_d[i] = pend_duty_q;
      end
    end
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      pwm_cnt_q   <= '0;
      pend_duty_q <= '1;
      for (int i = 0; i < NUM_LED; i++) begin
        duty_q[i] <= '1;
      end
    end else begin
      pwm_cnt_q   <= pwm_cnt_d;
      pend_duty_q <= pend_duty_d;
      for (int i = 0; i < NUM_LED; i++) begin
        duty_q[i] <= duty_d[i];
      end
    end
  end

  // Lit for duty+1 out of every 16 cycles while the pattern is high
  always_comb begin
    for (int i = 0; i < NUM_LED; i++) begin
      O_led_out[i] = pattern[i] & (pwm_cnt_q <= duty_q[i]);
    end
  end
`else
  assign O_led_out = pattern;
`endif

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// tb_led_pattern_ctrl
//   Directed bench for led_pattern_ctrl at 10 clocks per tick. A table of
//   timed records drives config writes and checks LED, busy and ready at
//   absolute cycle numbers counted from reset release; hand-written
//   sequences cover reset mid-pattern, back-to-back writes, zero
//   period/count, reserved mode, out-of-range index (on a 3-LED instance)
//   and, with LED_PWM_DIM_EN, PWM dimming.
module tb_led_pattern_ctrl;

  logic        clk;
  logic        rst_n;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [1:0]  cfg_idx;
  logic [2:0]  cfg_mode;
  logic [15:0] cfg_period;
  logic [3:0]  cfg_count;
  logic [3:0]  led_out;
  logic [3:0]  busy;

  logic        cfg_valid3;
  logic        cfg_ready3;
  logic [1:0]  cfg_idx3;
  logic [2:0]  cfg_mode3;
  logic [2:0]  led_out3;
  logic [2:0]  busy3;

`ifdef LED_PWM_DIM_EN
  logic [3:0]  cfg_duty;
  logic [3:0]  cfg_duty3;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  led_pattern_ctrl #(
    .CLK_FREQ_HZ (100),
    .TICK_HZ     (10),
    .NUM_LED     (4),
    .PERIOD_W    (16)
  ) dut (
    .I_clk        (clk),
    .I_rst_n      (rst_n),
    .I_cfg_valid  (cfg_valid),
    .O_cfg_ready  (cfg_ready),
    .I_cfg_idx    (cfg_idx),
    .I_cfg_mode   (cfg_mode),
    .I_cfg_period (cfg_period),
    .I_cfg_count  (cfg_count),
`ifdef LED_PWM_DIM_EN
    .I_cfg_duty   (cfg_duty),
`endif
    .O_led_out    (led_out),
    .O_busy       (busy)
  );

  led_pattern_ctrl #(
    .CLK_FREQ_HZ (100),
    .TICK_HZ     (10),
    .NUM_LED     (3),
    .PERIOD_W    (16)
  ) dut3 (
    .I_clk        (clk),
    .I_rst_n      (rst_n),
    .I_cfg_valid  (cfg_valid3),
    .O_cfg_ready  (cfg_ready3),
    .I_cfg_idx    (cfg_idx3),
    .I_cfg_mode   (cfg_mode3),
    .I_cfg_period (16'd1),
    .I_cfg_count  (4'd1),
`ifdef LED_PWM_DIM_EN
    .I_cfg_duty   (cfg_duty3),
`endif
    .O_led_out    (led_out3),
    .O_busy       (busy3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [3:0]  exp_led;
    logic [3:0]  exp_busy;
    logic        exp_rdy;
    logic        wr;
    logic [1:0]  idx;
    logic [2:0]  mode;
    logic [15:0] period;
    logic [3:0]  count;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(int c, logic [3:0] l, logic [3:0] b, logic r,
                              logic w, logic [1:0] i, logic [2:0] m,
                              logic [15:0] p, logic [3:0] n);
    vec_t v;
    v.cyc = c; v.exp_led = l; v.exp_busy = b; v.exp_rdy = r;
    v.wr = w; v.idx = i; v.mode = m; v.period = p; v.count = n;
    return v;
  endfunction

  task automatic check_output(input string nm, input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Advance to 1 ns after the posedge numbered c (counted from reset release)
  task automatic clk_to(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic apply_stimulus(input logic [1:0] idx, input logic [2:0] mode,
                                input logic [15:0] per, input logic [3:0] cnt);
    cfg_valid  = 1'b1;
    cfg_idx    = idx;
    cfg_mode   = mode;
    cfg_period = per;
    cfg_count  = cnt;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  int lit;

  initial begin
    rst_n      = 1'b0;
    cfg_valid  = 1'b0;
    cfg_idx    = '0;
    cfg_mode   = '0;
    cfg_period = '0;
    cfg_count  = '0;
    cfg_valid3 = 1'b0;
    cfg_idx3   = '0;
    cfg_mode3  = '0;
`ifdef LED_PWM_DIM_EN
    cfg_duty   = 4'd15;
    cfg_duty3  = 4'd15;
`endif

    // Reset state
    #23;
    check_output("rst_led",   32'(led_out),   32'h0);
    check_output("rst_busy",  32'(busy),      32'h0);
    check_output("rst_ready", 32'(cfg_ready), 32'h1);
    release_reset();

    // cyc, led, busy, ready, wr, idx, mode, period, count
    vecs.push_back(mk(  2, 4'b0000, 4'b0000, 1, 1, 2'd1, 3'd2, 16'd2, 4'd0));
    vecs.push_back(mk(  3, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(  9, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk( 10, 4'b0010, 4'b0000, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk( 29, 4'b0010, 4'b0000, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk( 30, 4'b0000, 4'b0000, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk( 49, 4'b0000, 4'b0000, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk( 51, 4'b0010, 4'b0000, 1, 1, 2'd0, 3'd3, 16'd1, 4'd3));
    vecs.push_back(mk( 52, 4'b0010, 4'b0000, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk( 59, 4'b0010, 4'b0000, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk( 60, 4'b0011, 4'b0000, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk( 70, 4'b0000, 4'b0000, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk( 80, 4'b0001, 4'b0000, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk( 90, 4'b0010, 4'b0000, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(100, 4'b0011, 4'b0000, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(110, 4'b0000, 4'b0000, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(120, 4'b0000, 4'b0000, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(149, 4'b0010, 4'b0000, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(150, 4'b0000, 4'b0000, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(151, 4'b0000, 4'b0000, 1, 1, 2'd2, 3'd4, 16'd5, 4'd0));
    vecs.push_back(mk(159, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(160, 4'b0101, 4'b0100, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(209, 4'b0101, 4'b0100, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(210, 4'b0010, 4'b0000, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(211, 4'b0010, 4'b0000, 1, 1, 2'd2, 3'd4, 16'd5, 4'd0));
    vecs.push_back(mk(220, 4'b0110, 4'b0100, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(231, 4'b0100, 4'b0100, 1, 1, 2'd2, 3'd0, 16'd1, 4'd0));
    vecs.push_back(mk(239, 4'b0100, 4'b0100, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(240, 4'b0000, 4'b0000, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(251, 4'b0010, 4'b0000, 1, 0, 0, 0, 0, 0));

    foreach (vecs[k]) begin
      clk_to(vecs[k].cyc);
      check_output($sformatf("v%0d_led", k),   32'(led_out),   32'(vecs[k].exp_led));
      check_output($sformatf("v%0d_busy", k),  32'(busy),      32'(vecs[k].exp_busy));
      check_output($sformatf("v%0d_ready", k), 32'(cfg_ready), 32'(vecs[k].exp_rdy));
      if (vecs[k].wr) begin
        apply_stimulus(vecs[k].idx, vecs[k].mode, vecs[k].period, vecs[k].count);
        clk_to(vecs[k].cyc + 1);
        cfg_valid = 1'b0;
      end
    end

    // Reset mid-BLINK: outputs clear asynchronously and stay clear
    #2;
    rst_n = 1'b0;
    #1;
    check_output("midrst_led",   32'(led_out),   32'h0);
    check_output("midrst_busy",  32'(busy),      32'h0);
    check_output("midrst_ready", 32'(cfg_ready), 32'h1);
    @(negedge clk);
    release_reset();
    clk_to(25);
    check_output("postrst_led", 32'(led_out), 32'h0);

    // Back-to-back writes, zero period/count, reserved mode, dropped index
    clk_to(32);
    apply_stimulus(2'd0, 3'd3, 16'd0, 4'd0);
    cfg_valid3 = 1'b1;
    cfg_idx3   = 2'd3;
    cfg_mode3  = 3'd1;
    clk_to(33);
    check_output("b2b_ready_a", 32'(cfg_ready),  32'h0);
    check_output("oor_ready_a", 32'(cfg_ready3), 32'h0);
    apply_stimulus(2'd3, 3'd2, 16'd0, 4'd0);
    cfg_valid3 = 1'b0;
    clk_to(35);
    check_output("b2b_held", 32'(cfg_ready), 32'h0);
    clk_to(39);
    check_output("b2b_led39",   32'(led_out),   32'h0);
    check_output("b2b_ready39", 32'(cfg_ready), 32'h0);
    clk_to(40);
    check_output("b2b_led40",   32'(led_out),    32'h1);
    check_output("b2b_ready40", 32'(cfg_ready),  32'h1);
    check_output("oor_led",     32'(led_out3),   32'h0);
    check_output("oor_ready",   32'(cfg_ready3), 32'h1);
    cfg_valid3 = 1'b1;
    cfg_idx3   = 2'd2;
    cfg_mode3  = 3'd1;
    clk_to(41);
    check_output("b2b_ready41", 32'(cfg_ready), 32'h0);
    cfg_valid  = 1'b0;
    cfg_valid3 = 1'b0;
    clk_to(50);
    check_output("b2b_led50", 32'(led_out),  32'h8);
    check_output("in_rng3",   32'(led_out3), 32'h4);
    clk_to(60);
    check_output("b2b_led60", 32'(led_out), 32'h0);
    clk_to(70);
    check_output("b2b_led70", 32'(led_out), 32'h8);
    clk_to(100);
    check_output("b2b_led100", 32'(led_out), 32'h1);
    apply_stimulus(2'd3, 3'd6, 16'd1, 4'd1);
    clk_to(101);
    cfg_valid = 1'b0;
    clk_to(110);
    check_output("rsv_led110", 32'(led_out), 32'h0);
    clk_to(120);
    check_output("rsv_led120", 32'(led_out), 32'h0);

`ifdef LED_PWM_DIM_EN
    // PWM dimming on channel 1: duty 3 then duty 15
    clk_to(121);
    cfg_duty = 4'd3;
    apply_stimulus(2'd1, 3'd1, 16'd1, 4'd1);
    clk_to(122);
    cfg_valid = 1'b0;
    clk_to(130);
    lit = 0;
    for (int i = 0; i < 16; i++) begin
      clk_to(cyc + 1);
      lit += int'(led_out[1]);
    end
    check_output("pwm_duty3", 32'(lit), 32'd4);
    cfg_duty = 4'd15;
    apply_stimulus(2'd1, 3'd1, 16'd1, 4'd1);
    clk_to(cyc + 1);
    cfg_valid = 1'b0;
    clk_to(160);
    lit = 0;
    for (int i = 0; i < 16; i++) begin
      clk_to(cyc + 1);
      lit += int'(led_out[1]);
    end
    check_output("pwm_duty15", 32'(lit), 32'd16);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
